layernorm_stream: RTL

- Streaming, parametrised LayerNorm/RMSNorm engine for the transformer datapath.
- Accepts one vector of D elements, one element per beat, over a valid/ready stream, with per-element gamma/beta.
- Buffers the vector and computes mean and variance in a single pass, then rsqrt via a shift-normalised LUT.
- Emits y_i = sat(gamma_i*(x_i-mean)*rsqrt + beta_i) on a backpressured output stream. RMS mode skips mean subtraction.

---
 rtl/layernorm_pkg.sv | 48 ++++
 rtl/rsqrt_norm_lut.sv | 97 +++++++++
 rtl/layernorm_stream.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/layernorm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : layernorm_pkg
//  Description : Shared widths, FSM state type and saturation helper for the
//                streaming LayerNorm / RMSNorm engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package layernorm_pkg;

  // Width of the generic saturation helper's working value.
  localparam int c_SAT_W = 64;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    STAT  = 2'd1,
    RSQRT = 2'd2,
    EMIT  = 2'd3
  } ln_state_t;

  // Signed running sum of D elements of width dw.
  function automatic int acc1_w(input int dw, input int log2d);
    return dw + log2d;
  endfunction

  // Unsigned running sum of D squares of width-dw elements.
  function automatic int acc2_w(input int dw, input int log2d);
    return 2 * dw + log2d;
  endfunction

  // rsqrt carries one integer bit so that rsqrt(0 or 1) = 1.0 is representable.
  function automatic int rs_w(input int frac_w);
    return frac_w + 1;
  endfunction

  // Clamp a signed value to the range of an out_w-bit signed number.
  function automatic logic signed [c_SAT_W-1:0] sat(input logic signed [c_SAT_W-1:0] v,
                                                   input int out_w);
    logic signed [c_SAT_W-1:0] hi;
    logic signed [c_SAT_W-1:0] lo;
    hi = (c_SAT_W'(1) <<< (out_w - 1)) - c_SAT_W'(1);
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rsqrt_norm_lut.sv
`default_nettype none
// ============================================================================
//  Module      : rsqrt_norm_lut
//  Description : Reciprocal square root of an unsigned variance. The input is
//                normalised by the smallest even right shift that brings it
//                below 2^ADDR_W, looked up in a table built at elaboration,
//                and the result is shifted right by half the normalising shift.
//                Two-cycle latency, fully pipelined.
//  Revision    : 1.0 - initial release
// ============================================================================
module rsqrt_norm_lut
  import layernorm_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int FRAC_W = 8,
  parameter int VAR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [VAR_W-1:0]  in_var,
  output logic              out_valid,
  output logic [FRAC_W:0]   out_rs
);

  localparam int c_RS_W   = rs_w(FRAC_W);
  // Even shifts 0,2,..,2*(c_NSH-1); the last one always empties in_var.
  localparam int c_NSH    = (VAR_W + 1) / 2 + 1;
  localparam int c_HALF_W = $clog2(c_NSH + 1);
  localparam int c_DEPTH  = 2 ** ADDR_W;

  // round(2^FRAC_W / sqrt(max(idx,1))) as the largest r with
  // (2r-1)^2 * idx <= 4^(FRAC_W+1), found by a bitwise search.
  function automatic logic [c_RS_W-1:0] rsqrt_entry(input int idx);
    longint unsigned den;
    longint unsigned lim;
    longint unsigned r;
    longint unsigned t;
    den = (idx < 1) ? 64'd1 : 64'(idx);
    lim = 64'd1 << (2 * FRAC_W + 2);
    r   = 64'd0;
    for (int b = FRAC_W; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if ((64'd2 * t - 64'd1) * (64'd2 * t - 64'd1) * den <= lim) r = t;
    end
    return c_RS_W'(r);
  endfunction

  logic [c_RS_W-1:0]   w_lut [c_DEPTH];
  logic [c_HALF_W-1:0] w_half;
  logic [ADDR_W-1:0]   w_idx;

  logic                r_v1;
  logic [ADDR_W-1:0]   r_idx;
  logic [c_HALF_W-1:0] r_half;
  logic                r_v2;
  logic [c_RS_W-1:0]   r_rs;

  for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_lut
    assign w_lut[gi] = rsqrt_entry(gi);
  end

  // Pick the smallest even shift (stored as shift/2) that fits the table index.
  always_comb begin
    w_half = '0;
    for (int k = c_NSH - 1; k >= 0; k--) begin
      if (((in_var >> (2 * k)) >> ADDR_W) == '0) w_half = c_HALF_W'(k);
    end
  end

  assign w_idx = ADDR_W'(in_var >> (2 * w_half));

  // Stage 1 registers the normalised index; stage 2 looks up and denormalises.
  // The result is held until the next request so the consumer can reuse it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_idx  <= '0;
      r_half <= '0;
      r_v2   <= 1'b0;
      r_rs   <= '0;
    end else begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      if (in_valid) begin
        r_idx  <= w_idx;
        r_half <= w_half;
      end
      if (r_v1) r_rs <= w_lut[r_idx] >> r_half;
    end
  end

  assign out_valid = r_v2;
  assign out_rs    = r_rs;

endmodule
`default_nettype wire

// File: rtl/layernorm_stream.sv
`default_nettype none
// ============================================================================
//  Module      : layernorm_stream
//  Description : Streaming LayerNorm / RMSNorm over D-element vectors. Buffers
//                one vector while accumulating sum and sum of squares, derives
//                mean and variance, obtains rsqrt from rsqrt_norm_lut and emits
//                sat(gamma*(x-mean)*rsqrt + beta) on a backpressured stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module layernorm_stream
  import layernorm_pkg::*;
#(
  parameter int D      = 64,
  parameter int DW     = 8,
  parameter int FRAC_W = 8,
  parameter int ADDR_W = 8,
  parameter int G_FRAC = 6,
  parameter int OUT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DW-1:0]    in_x,
  input  logic signed [DW-1:0]    in_gamma,
  input  logic signed [DW-1:0]    in_beta,
  input  logic                    in_last,
  input  logic                    rms_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_y,
  output logic                    out_last,
  output logic                    err_len
);

  localparam int c_LOG2D  = $clog2(D);
  localparam int c_ACC1_W = acc1_w(DW, c_LOG2D);
  localparam int c_ACC2_W = acc2_w(DW, c_LOG2D);
  localparam int c_RS_W   = rs_w(FRAC_W);
  localparam int c_SQ_W   = 2 * DW;
  localparam int c_VAR_W  = c_SQ_W;
  localparam int c_D_W    = DW + 1;
  localparam int c_P_W    = c_D_W + (c_RS_W + 1) + DW;
  localparam int c_SH     = FRAC_W + G_FRAC;

  ln_state_t r_state;
  ln_state_t w_state_nxt;

  logic [c_LOG2D-1:0]         r_cnt;
  logic [c_LOG2D-1:0]         r_ocnt;
  logic signed [c_ACC1_W-1:0] r_sum;
  logic [c_ACC2_W-1:0]        r_sumsq;
  logic                       r_rms;
  logic signed [DW-1:0]       r_mean;
  logic                       r_in_ready;
  logic                       r_err;
  logic                       r_out_valid;
  logic                       r_out_last;
  logic signed [OUT_W-1:0]    r_out_y;

  logic signed [DW-1:0]       r_bx [D];
  logic signed [DW-1:0]       r_bg [D];
  logic signed [DW-1:0]       r_bb [D];

  logic                       w_take;
  logic                       w_cnt_end;
  logic                       w_len_err;
  logic                       w_vec_done;
  logic                       w_adv;
  logic                       w_load_out;
  logic                       w_final;
  logic signed [c_SQ_W-1:0]   w_xsq;
  logic signed [DW-1:0]       w_mean_ln;
  logic signed [c_SQ_W-1:0]   w_mean_sq;
  logic [c_VAR_W-1:0]         w_ms;
  logic [c_VAR_W-1:0]         w_var;
  logic signed [DW-1:0]       w_mean_use;
  logic                       w_rs_start;
  logic                       w_rs_valid;
  logic [c_RS_W-1:0]          w_rs;
  logic signed [c_D_W-1:0]    w_d;
  logic signed [c_P_W-1:0]    w_p;
  logic signed [c_P_W-1:0]    w_q;
  logic signed [OUT_W-1:0]    w_y;

  // ---------------------------------------------------------------- input side
  assign w_take     = (r_state == LOAD) && r_in_ready && in_valid;
  assign w_cnt_end  = (r_cnt == c_LOG2D'(D - 1));
  assign w_len_err  = w_take && (in_last != w_cnt_end);
  assign w_vec_done = w_take && in_last && w_cnt_end;
  assign w_xsq      = c_SQ_W'(in_x) * c_SQ_W'(in_x);

  // ---------------------------------------------------------------- statistics
  assign w_mean_ln  = DW'(r_sum >>> c_LOG2D);
  assign w_mean_sq  = c_SQ_W'(w_mean_ln) * c_SQ_W'(w_mean_ln);
  assign w_ms       = c_VAR_W'(r_sumsq >> c_LOG2D);
  // The floored mean can make mean^2 exceed ms slightly, hence the clamp.
  assign w_var      = r_rms ? w_ms
                    : ((w_ms >= $unsigned(w_mean_sq)) ? (w_ms - $unsigned(w_mean_sq)) : '0);
  assign w_mean_use = r_rms ? '0 : w_mean_ln;
  assign w_rs_start = (r_state == STAT);

  rsqrt_norm_lut #(
    .ADDR_W (ADDR_W),
    .FRAC_W (FRAC_W),
    .VAR_W  (c_VAR_W)
  ) u_rsqrt (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_rs_start),
    .in_var    (w_var),
    .out_valid (w_rs_valid),
    .out_rs    (w_rs)
  );

  // ---------------------------------------------------------------- output side
  assign w_adv = !r_out_valid || out_ready;

  // Normalise the buffered element selected by r_ocnt.
  always_comb begin
    w_d = c_D_W'(r_bx[r_ocnt]) - c_D_W'(r_mean);
    w_p = c_P_W'(w_d) * c_P_W'($signed({1'b0, w_rs})) * c_P_W'(r_bg[r_ocnt]);
    w_q = (w_p >>> c_SH) + c_P_W'(r_bb[r_ocnt]);
    w_y = OUT_W'(sat(c_SAT_W'(w_q), OUT_W));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_state_nxt;
  end

  // Next state plus output-register load / vector-complete strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_load_out  = 1'b0;
    w_final     = 1'b0;
    case (r_state)
      LOAD: begin
        if (w_vec_done) w_state_nxt = STAT;
      end
      STAT: begin
        w_state_nxt = RSQRT;
      end
      RSQRT: begin
        if (w_rs_valid) begin
          w_load_out  = 1'b1;
          w_state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (r_out_valid && r_out_last) begin
          if (out_ready) begin
            w_final     = 1'b1;
            w_state_nxt = LOAD;
          end
        end else if (w_adv) begin
          w_load_out = 1'b1;
        end
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  // Accumulators, beat counter, mode latch, mean register and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_sum      <= '0;
      r_sumsq    <= '0;
      r_rms      <= 1'b0;
      r_mean     <= '0;
      r_err      <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      r_err      <= w_len_err;
      r_in_ready <= (w_state_nxt == LOAD);
      if (w_take) begin
        if (r_cnt == '0) r_rms <= rms_mode;
        if (w_len_err) begin
          r_cnt   <= '0;
          r_sum   <= '0;
          r_sumsq <= '0;
        end else begin
          r_sum   <= r_sum + c_ACC1_W'(in_x);
          r_sumsq <= r_sumsq + c_ACC2_W'($unsigned(w_xsq));
          r_cnt   <= w_cnt_end ? '0 : r_cnt + 1'b1;
        end
      end
      if (r_state == STAT) r_mean <= w_mean_use;
      if (w_final) begin
        r_sum   <= '0;
        r_sumsq <= '0;
      end
    end
  end

  // Element buffer; contents are only meaningful for a complete vector.
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_bx[r_cnt] <= in_x;
      r_bg[r_cnt] <= in_gamma;
      r_bb[r_cnt] <= in_beta;
    end
  end

  // Output register: advances only when empty or being consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
      r_out_last  <= 1'b0;
      r_ocnt      <= '0;
    end else if (w_load_out) begin
      r_out_valid <= 1'b1;
      r_out_y     <= w_y;
      r_out_last  <= (r_ocnt == c_LOG2D'(D - 1));
      r_ocnt      <= r_ocnt + 1'b1;
    end else if (w_final) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_ocnt      <= '0;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_y     = r_out_y;
  assign out_last  = r_out_last;
  assign err_len   = r_err;

endmodule
`default_nettype wire
